stopwatch_lap_ctrl: RTL and testbench

// - Parametrised stopwatch controller: drives up/down enables for an N-stage external digit-counter chain.
// - Run/pause/clear FSM, per-stage cursor for manual set, and a lap-snapshot FIFO with valid/ready read port.
// - Sits between the debounced button pulses and the time-counter stages; the lap FIFO feeds the display/readout path.

---
 rtl/stopwatch_lap_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch run/pause/clear/set controller with lap-snapshot FIFO (0-cycle enables, 1-cycle o_clr, lap visible 1 cycle after capture).
// Lap read is valid/ready; a lap pushed into a full FIFO is dropped, or overwrites the oldest entry when STOPWATCH_LAP_OVERWRITE_EN is defined.

module lap_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [W-1:0]     pop_dat,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_pop, do_write, adv_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign pop_vld = (count != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop_vld && pop_rdy;

  always_comb begin
    do_write = 1'b0;
    adv_rd   = 1'b0;
    if (!flush) begin
`ifdef STOPWATCH_LAP_OVERWRITE_EN
      // On full, the newest lap evicts the oldest by pushing the read pointer along.
      do_write = push;
      adv_rd   = do_pop || (push && full);
`else
      do_write = push && (!full || do_pop);
      adv_rd   = do_pop;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_write) - CNT_W'(adv_rd);
      if (push && full && !do_pop) ovf <= 1'b1;
    end
  end
endmodule

module stopwatch_lap_ctrl #(
  parameter int N_STAGES  = 4,
  parameter int TIME_W    = 24,
  parameter int LAP_DEPTH = 8,
  localparam int SEL_W = $clog2(N_STAGES),
  localparam int CNT_W = $clog2(LAP_DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_tick,
  input  logic                i_start_stop,
  input  logic                i_lap,
  input  logic                i_clear,
  input  logic                i_set,
  input  logic                i_left,
  input  logic                i_right,
  input  logic                i_adj_up,
  input  logic                i_adj_down,
  input  logic [N_STAGES-1:0] i_carry,
  input  logic [TIME_W-1:0]   i_time,
  output logic [N_STAGES-1:0] o_up,
  output logic [N_STAGES-1:0] o_down,
  output logic                o_clr,
  output logic [1:0]          o_state,
  output logic [SEL_W-1:0]    o_sel,
  output logic                o_lap_valid,
  input  logic                i_lap_ready,
  output logic [TIME_W-1:0]   o_lap_data,
  output logic [CNT_W-1:0]    o_lap_count,
  output logic                o_lap_ovf
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_SET   = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel;
  logic             clear_acc, lap_push, clr_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear_acc = 1'b0;
    o_up      = '0;
    o_down    = '0;
    if (i_set) begin
      state_nxt = ST_SET;
    end else begin
      unique case (state)
        ST_IDLE: begin
          clear_acc = i_clear;
          if (i_start_stop) state_nxt = ST_RUN;
        end
        ST_RUN: if (i_start_stop) state_nxt = ST_PAUSE;
        ST_PAUSE: begin
          clear_acc = i_clear;
          if (i_clear)           state_nxt = ST_IDLE;
          else if (i_start_stop) state_nxt = ST_RUN;
        end
        ST_SET: state_nxt = ST_PAUSE;
        default: state_nxt = ST_IDLE;
      endcase
    end

    if (state == ST_RUN) begin
      o_up = {i_carry[N_STAGES-2:0], i_tick};
    end else if (state == ST_SET && (i_adj_up != i_adj_down)) begin
      for (int k = 0; k < N_STAGES; k++) begin
        o_up[k]   = i_adj_up   && (sel == SEL_W'(k));
        o_down[k] = i_adj_down && (sel == SEL_W'(k));
      end
    end
  end

  // Left moves toward the most significant stage; both at once cancel.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sel <= '0;
    end else if (state == ST_SET) begin
      if (i_left && !i_right)
        sel <= (sel == SEL_W'(N_STAGES - 1)) ? '0 : sel + 1'b1;
      else if (i_right && !i_left)
        sel <= (sel == '0) ? SEL_W'(N_STAGES - 1) : sel - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) clr_q <= 1'b0;
    else         clr_q <= clear_acc;
  end

  assign lap_push = i_lap && (state == ST_RUN);
  assign o_clr    = clr_q;
  assign o_state  = state;
  assign o_sel    = sel;

  lap_fifo #(
    .W     (TIME_W),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk      (i_clk),
    .rst_n    (i_rstn),
    .flush    (clear_acc),
    .push     (lap_push),
    .push_dat (i_time),
    .pop_rdy  (i_lap_ready),
    .pop_vld  (o_lap_valid),
    .pop_dat  (o_lap_data),
    .count    (o_lap_count),
    .ovf      (o_lap_ovf)
  );
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl (N_STAGES=4, TIME_W=24, LAP_DEPTH=8).
module tb_stopwatch_lap_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        tick, start_stop, lap, clear, set, left, right, adj_up, adj_down;
  logic [3:0]  carry;
  logic [23:0] time_val;
  logic [3:0]  up, down;
  logic        clr;
  logic [1:0]  state;
  logic [1:0]  sel;
  logic        lap_valid, lap_ready;
  logic [23:0] lap_data;
  logic [3:0]  lap_count;
  logic        lap_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_lap_ctrl #(
    .N_STAGES  (4),
    .TIME_W    (24),
    .LAP_DEPTH (8)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_tick       (tick),
    .i_start_stop (start_stop),
    .i_lap        (lap),
    .i_clear      (clear),
    .i_set        (set),
    .i_left       (left),
    .i_right      (right),
    .i_adj_up     (adj_up),
    .i_adj_down   (adj_down),
    .i_carry      (carry),
    .i_time       (time_val),
    .o_up         (up),
    .o_down       (down),
    .o_clr        (clr),
    .o_state      (state),
    .o_sel        (sel),
    .o_lap_valid  (lap_valid),
    .i_lap_ready  (lap_ready),
    .o_lap_data   (lap_data),
    .o_lap_count  (lap_count),
    .o_lap_ovf    (lap_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [23:0] exp_head;

  initial begin
    rstn = 1'b0; tick = 0; start_stop = 0; lap = 0; clear = 0; set = 0;
    left = 0; right = 0; adj_up = 0; adj_down = 0; carry = '0; time_val = '0; lap_ready = 0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(lap_valid), 32'd0);
    chk("rst_count", 32'(lap_count), 32'd0);
    chk("rst_ovf", 32'(lap_ovf), 32'd0);
    chk("rst_clr", 32'(clr), 32'd0);
    rstn = 1'b1;
    step();

    // IDLE: ticks and carries must not propagate
    tick = 1; carry = 4'b0001; settle();
    chk("idle_up", 32'(up), 32'd0);
    chk("idle_down", 32'(down), 32'd0);

    start_stop = 1; step(); start_stop = 0;
    chk("run_state", 32'(state), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick = (i % 2 == 0); settle();
      chk("run_up", 32'(up), (i % 2 == 0) ? 32'h3 : 32'h2);
      chk("run_down", 32'(down), 32'd0);
      step();
    end
    tick = 0; carry = '0;

    // Two laps, then drain
    time_val = 24'h000123; lap = 1; step();
    chk("lap1_valid", 32'(lap_valid), 32'd1);
    chk("lap1_count", 32'(lap_count), 32'd1);
    time_val = 24'h000456; step(); lap = 0;
    chk("lap2_count", 32'(lap_count), 32'd2);
    chk("lap2_head", 32'(lap_data), 32'h123);
    lap_ready = 1; step();
    chk("pop1_count", 32'(lap_count), 32'd1);
    chk("pop1_head", 32'(lap_data), 32'h456);
    step(); lap_ready = 0;
    chk("pop2_count", 32'(lap_count), 32'd0);
    chk("pop2_valid", 32'(lap_valid), 32'd0);

    // Nine laps into an eight-entry FIFO
    for (int k = 1; k <= 9; k++) begin
      time_val = 24'(k * 17); lap = 1; step();
    end
    lap = 0;
    chk("ovf9_count", 32'(lap_count), 32'd8);
    chk("ovf9_flag", 32'(lap_ovf), 32'd1);
`ifdef STOPWATCH_LAP_OVERWRITE_EN
    exp_head = 24'h22;
`else
    exp_head = 24'h11;
`endif
    chk("ovf9_head", 32'(lap_data), 32'(exp_head));

    // Pause, then clear beats start_stop
    start_stop = 1; step(); start_stop = 0;
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_clr", 32'(clr), 32'd0);
    start_stop = 1; clear = 1; step(); start_stop = 0; clear = 0;
    chk("clear_state", 32'(state), 32'd0);
    chk("clear_pulse", 32'(clr), 32'd1);
    chk("clear_count", 32'(lap_count), 32'd0);
    chk("clear_ovf", 32'(lap_ovf), 32'd0);
    step();
    chk("clear_pulse_end", 32'(clr), 32'd0);

    // Refill to full, check clear is ignored in RUN
    start_stop = 1; step(); start_stop = 0;
    for (int k = 1; k <= 8; k++) begin
      time_val = 24'h200 + 24'(k); lap = 1; step();
    end
    lap = 0;
    chk("full_count", 32'(lap_count), 32'd8);
    chk("full_ovf", 32'(lap_ovf), 32'd0);
    chk("full_head", 32'(lap_data), 32'h201);
    clear = 1; step(); clear = 0;
    chk("runclr_state", 32'(state), 32'd1);
    chk("runclr_count", 32'(lap_count), 32'd8);
    step();
    chk("runclr_pulse", 32'(clr), 32'd0);

    // Push and pop together on a full FIFO
    time_val = 24'h2FF; lap = 1; lap_ready = 1; step(); lap = 0; lap_ready = 0;
    chk("pp_count", 32'(lap_count), 32'd8);
    chk("pp_ovf", 32'(lap_ovf), 32'd0);
    chk("pp_head", 32'(lap_data), 32'h202);

    // Set mode: cursor and manual adjust
    set = 1; step();
    chk("set_state", 32'(state), 32'd3);
    tick = 1; carry = 4'b1111; settle();
    chk("set_noadj_up", 32'(up), 32'd0);
    tick = 0; carry = '0;
    for (int i = 1; i <= 4; i++) begin
      left = 1; step(); left = 0;
      chk("set_left", 32'(sel), 32'(i % 4));
    end
    right = 1; step(); right = 0;
    chk("set_right_wrap", 32'(sel), 32'd3);
    left = 1; right = 1; step(); left = 0; right = 0;
    chk("set_both_hold", 32'(sel), 32'd3);
    adj_up = 1; settle();
    chk("set_up3", 32'(up), 32'h8);
    adj_up = 0;
    left = 1; step(); left = 0;
    adj_up = 1; settle();
    chk("set_up0", 32'(up), 32'h1);
    chk("set_up0_down", 32'(down), 32'h0);
    adj_up = 0; adj_down = 1; settle();
    chk("set_down0", 32'(down), 32'h1);
    chk("set_down0_up", 32'(up), 32'h0);
    adj_up = 1; settle();
    chk("set_both_up", 32'(up), 32'h0);
    chk("set_both_down", 32'(down), 32'h0);
    adj_up = 0; adj_down = 0;
    left = 1; step(); left = 0;
    set = 0; step();
    chk("unset_state", 32'(state), 32'd2);
    chk("unset_sel", 32'(sel), 32'd1);
    left = 1; step(); left = 0;
    chk("pause_sel_hold", 32'(sel), 32'd1);

    // Asynchronous reset mid-run
    start_stop = 1; step(); start_stop = 0;
    chk("rerun_state", 32'(state), 32'd1);
    #3 rstn = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_count", 32'(lap_count), 32'd0);
    chk("arst_valid", 32'(lap_valid), 32'd0);
    #10 rstn = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
